// File: rtl/brick_grid_pkg.sv
// Shared brick-grid geometry, colours and helpers for the grid drawer and the
// collision logic, so both agree on identical brick placement.
package brick_grid_pkg;

   localparam int DEF_ROWS         = 4;
   localparam int DEF_COLS         = 4;
   localparam int DEF_X0           = 20;
   localparam int DEF_Y0           = 40;
   localparam int DEF_B_WIDTH      = 100;
   localparam int DEF_B_HEIGHT     = 50;
   localparam int DEF_H_GAP        = 120;
   localparam int DEF_V_GAP        = 30;
   localparam int DEF_FLASH_FRAMES = 8;

   localparam int CW = 11;

   typedef logic [CW-1:0] coord_t;
   typedef logic [11:0]   rgb_t;

   localparam rgb_t COLOR_BRICK_DEF = 12'h22f;
   localparam rgb_t COLOR_FLASH_DEF = 12'hfff;
   localparam rgb_t COLOR_BG_DEF    = 12'h888;
   localparam rgb_t COLOR_BLANK     = 12'h000;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } pix_pos_t;

   typedef struct packed {
      coord_t hcount;
      logic   hsync;
      logic   hblnk;
      coord_t vcount;
      logic   vsync;
      logic   vblnk;
   } vga_timing_t;

   // Index width for n bricks; a single brick still needs a 1-bit index port.
   function automatic int calc_iw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic pix_pos_t brick_base(input int row, input int col,
                                           input int x0, input int y0,
                                           input int bw, input int bh,
                                           input int hgap, input int vgap);
      pix_pos_t p;
      p.x = coord_t'(x0 + col * (bw + hgap));
      p.y = coord_t'(y0 + row * (bh + vgap));
      return p;
   endfunction

endpackage

// File: rtl/draw_brick_grid_flash_ctrl.sv
// Brick alive state and hit-flash control: load/hit priority, frame-tick
// detection on vblank rising edge, and the per-frame flash countdown.
module brick_flash_ctrl
   import brick_grid_pkg::*;
#(
   parameter int            N            = 16,
   parameter int            IW           = 4,
   parameter logic [N-1:0]  INIT_MASK    = '1,
   parameter int            FLASH_FRAMES = 8
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic          vblnk_i,
   input  logic          hit_valid_i,
   input  logic [IW-1:0] hit_idx_i,
   input  logic          load_valid_i,
   input  logic [N-1:0]  load_mask_i,
   output logic [N-1:0]  alive_o,
   output logic [IW-1:0] flash_idx_o,
   output logic          flash_active_o,
   output logic          all_cleared_o
);

   logic [N-1:0]  alive_q, alive_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [IW-1:0] fidx_q, fidx_d;
   logic          vblnk_q;
   logic          all_cleared_q;
   logic          frame_tick;
   logic          hit_ok;

   assign frame_tick = vblnk_i & ~vblnk_q;
   assign hit_ok     = hit_valid_i && (int'(hit_idx_i) < N) && alive_q[hit_idx_i];

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path
      // through this block leaves it unassigned (which would infer a latch).
      alive_d = alive_q;
      cnt_d   = cnt_q;
      fidx_d  = fidx_q;
      if (load_valid_i) begin
         alive_d = load_mask_i;
         cnt_d   = '0;
      end else if (hit_ok) begin
         alive_d[hit_idx_i] = 1'b0;
         fidx_d             = hit_idx_i;
         cnt_d              = 8'(FLASH_FRAMES);
      end else if (frame_tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         alive_q       <= INIT_MASK;
         cnt_q         <= '0;
         fidx_q        <= '0;
         vblnk_q       <= 1'b0;
         all_cleared_q <= (INIT_MASK == '0);
      end else begin
         alive_q       <= alive_d;
         cnt_q         <= cnt_d;
         fidx_q        <= fidx_d;
         vblnk_q       <= vblnk_i;
         all_cleared_q <= (alive_d == '0) && (cnt_d == '0);
      end
   end

   assign alive_o        = alive_q;
   assign flash_idx_o    = fidx_q;
   assign flash_active_o = (cnt_q != '0);
   assign all_cleared_o  = all_cleared_q;

endmodule

// File: rtl/draw_brick_grid.sv
// Renders a ROWS x COLS brick grid into the VGA stream with a 2-cycle pixel
// pipeline; brick alive/flash state lives in brick_flash_ctrl.
module draw_brick_grid
   import brick_grid_pkg::*;
#(
   parameter int   ROWS         = DEF_ROWS,
   parameter int   COLS         = DEF_COLS,
   parameter int   X0           = DEF_X0,
   parameter int   Y0           = DEF_Y0,
   parameter int   B_WIDTH      = DEF_B_WIDTH,
   parameter int   B_HEIGHT     = DEF_B_HEIGHT,
   parameter int   H_GAP        = DEF_H_GAP,
   parameter int   V_GAP        = DEF_V_GAP,
   parameter logic [ROWS*COLS-1:0] INIT_MASK = '1,
   parameter rgb_t COLOR_BRICK  = COLOR_BRICK_DEF,
   parameter rgb_t COLOR_FLASH  = COLOR_FLASH_DEF,
   parameter rgb_t COLOR_BG     = COLOR_BG_DEF,
   parameter int   FLASH_FRAMES = DEF_FLASH_FRAMES,
   localparam int  NB           = ROWS * COLS,
   localparam int  IW           = calc_iw(ROWS * COLS)
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic [10:0]   hcount_in,
   input  logic          hsync_in,
   input  logic          hblnk_in,
   input  logic [10:0]   vcount_in,
   input  logic          vsync_in,
   input  logic          vblnk_in,
   input  logic          hit_valid,
   input  logic [IW-1:0] hit_idx,
   input  logic          load_valid,
   input  logic [NB-1:0] load_mask,
   output logic [10:0]   hcount_out,
   output logic          hsync_out,
   output logic          hblnk_out,
   output logic [10:0]   vcount_out,
   output logic          vsync_out,
   output logic          vblnk_out,
   output logic [11:0]   rgb_out,
   output logic [NB-1:0] blocks_out,
   output logic          flash_active,
   output logic          all_cleared
);

   vga_timing_t   tim_in, tim_s1_q, tim_s2_q;
   logic [COLS-1:0] col_match_d, col_match_q;
   logic [ROWS-1:0] row_match_d, row_match_q;
   logic          blank_q;
   logic [NB-1:0] alive;
   logic [IW-1:0] flash_idx;
   logic          pix_hit;
   logic [IW-1:0] pix_idx;
   rgb_t          rgb_d, rgb_q;

   assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                     vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

   brick_flash_ctrl #(
      .N            (NB),
      .IW           (IW),
      .INIT_MASK    (INIT_MASK),
      .FLASH_FRAMES (FLASH_FRAMES)
   ) u_flash_ctrl (
      .pclk           (pclk),
      .reset          (reset),
      .vblnk_i        (vblnk_in),
      .hit_valid_i    (hit_valid),
      .hit_idx_i      (hit_idx),
      .load_valid_i   (load_valid),
      .load_mask_i    (load_mask),
      .alive_o        (alive),
      .flash_idx_o    (flash_idx),
      .flash_active_o (flash_active),
      .all_cleared_o  (all_cleared)
   );

   // Half-open span compare against constant bases; the limit is 12 bits wide
   // so a brick ending at the edge of the 11-bit range cannot wrap.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam pix_pos_t POS = brick_base(0, c, X0, Y0, B_WIDTH, B_HEIGHT, H_GAP, V_GAP);
      localparam logic [11:0] LIMIT = {1'b0, POS.x} + 12'(B_WIDTH);
      assign col_match_d[c] = (hcount_in >= POS.x) && ({1'b0, hcount_in} < LIMIT);
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam pix_pos_t POS = brick_base(r, 0, X0, Y0, B_WIDTH, B_HEIGHT, H_GAP, V_GAP);
      localparam logic [11:0] LIMIT = {1'b0, POS.y} + 12'(B_HEIGHT);
      assign row_match_d[r] = (vcount_in >= POS.y) && ({1'b0, vcount_in} < LIMIT);
   end

   // Stage 1 blank resets high so the first pixel after reset is black.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         tim_s1_q    <= '0;
         col_match_q <= '0;
         row_match_q <= '0;
         blank_q     <= 1'b1;
      end else begin
         tim_s1_q    <= tim_in;
         col_match_q <= col_match_d;
         row_match_q <= row_match_d;
         blank_q     <= hblnk_in | vblnk_in;
      end
   end

   always_comb begin
      pix_hit = 1'b0;
      pix_idx = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (row_match_q[r] && col_match_q[c]) begin
               pix_hit = 1'b1;
               pix_idx = IW'(r * COLS + c);
            end
         end
      end
   end

   always_comb begin
      rgb_d = COLOR_BG;
      if (blank_q) begin
         rgb_d = COLOR_BLANK;
      end else if (pix_hit && flash_active && (pix_idx == flash_idx)) begin
         rgb_d = COLOR_FLASH;
      end else if (pix_hit && alive[pix_idx]) begin
         rgb_d = COLOR_BRICK;
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         tim_s2_q <= '0;
         rgb_q    <= '0;
      end else begin
         tim_s2_q <= tim_s1_q;
         rgb_q    <= rgb_d;
      end
   end

   assign hcount_out = tim_s2_q.hcount;
   assign hsync_out  = tim_s2_q.hsync;
   assign hblnk_out  = tim_s2_q.hblnk;
   assign vcount_out = tim_s2_q.vcount;
   assign vsync_out  = tim_s2_q.vsync;
   assign vblnk_out  = tim_s2_q.vblnk;
   assign rgb_out    = rgb_q;
   assign blocks_out = alive;

endmodule

// File: tb/tb_draw_brick_grid.sv
// Self-checking bench for draw_brick_grid: pixel vector table, hand-written
// flash/load sequences and randomized traffic against a geometric model.
module tb_draw_brick_grid;

   localparam int   ROWS = 4, COLS = 4, NB = 16;
   localparam int   X0 = 20, Y0 = 40, BW = 100, BH = 50, HG = 120, VG = 30;
   localparam int   FLASH = 8;
   localparam logic [11:0] C_BRICK = 12'h22f, C_FLASH = 12'hfff, C_BG = 12'h888;

   logic        pclk = 1'b0;
   logic        reset;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
   logic        hit_valid, load_valid;
   logic [3:0]  hit_idx;
   logic [15:0] load_mask;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [11:0] rgb_out;
   logic [15:0] blocks_out;
   logic        flash_active, all_cleared;

   always #5 pclk = ~pclk;

   draw_brick_grid dut (
      .pclk(pclk), .reset(reset),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .hit_valid(hit_valid), .hit_idx(hit_idx),
      .load_valid(load_valid), .load_mask(load_mask),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .blocks_out(blocks_out),
      .flash_active(flash_active), .all_cleared(all_cleared)
   );

   typedef struct packed {
      logic [10:0] h;
      logic        hs;
      logic        hb;
      logic [10:0] v;
      logic        vs;
      logic        vb;
   } pix_t;

   typedef struct {
      int          h;
      int          v;
      logic        hb;
      logic        vb;
      logic [11:0] exp_rgb;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: what the grid should hold after the most recent edge.
   logic [15:0] m_alive;
   int          m_cnt;
   int          m_fidx;
   logic        m_prev_vb;
   pix_t        m_prev;
   bit          m_skip_rgb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int axis_slot(input int pos, input int org, input int size,
                                    input int gap, input int n);
      int off;
      if (pos < org) return -1;
      off = pos - org;
      if (off / (size + gap) >= n) return -1;
      if (off % (size + gap) >= size) return -1;
      return off / (size + gap);
   endfunction

   function automatic logic [11:0] model_rgb(input pix_t p);
      int col, row, idx;
      if (p.hb || p.vb) return 12'h000;
      col = axis_slot(int'(p.h), X0, BW, HG, COLS);
      row = axis_slot(int'(p.v), Y0, BH, VG, ROWS);
      if (col < 0 || row < 0) return C_BG;
      idx = row * COLS + col;
      if (m_cnt != 0 && idx == m_fidx) return C_FLASH;
      if (m_alive[idx]) return C_BRICK;
      return C_BG;
   endfunction

   task automatic model_reset();
      m_alive    = 16'hffff;
      m_cnt      = 0;
      m_fidx     = 0;
      m_prev_vb  = 1'b0;
      m_prev     = '0;
      m_skip_rgb = 1'b1;
   endtask

   task automatic model_update(input pix_t p, input logic hv, input logic [3:0] hi,
                               input logic lv, input logic [15:0] lm);
      bit tick;
      tick = p.vb && !m_prev_vb;
      if (lv) begin
         m_alive = lm;
         m_cnt   = 0;
      end else if (hv && int'(hi) < NB && m_alive[hi]) begin
         m_alive[hi] = 1'b0;
         m_fidx      = int'(hi);
         m_cnt       = FLASH;
      end else if (tick && m_cnt > 0) begin
         m_cnt = m_cnt - 1;
      end
      m_prev_vb = p.vb;
   endtask

   // One pixel clock: drive inputs, advance the model, compare after the edge.
   task automatic step(input pix_t p, input logic hv, input logic [3:0] hi,
                       input logic lv, input logic [15:0] lm);
      logic [11:0] exp_rgb;
      pix_t        shown;
      hcount_in  = p.h;  hsync_in = p.hs; hblnk_in = p.hb;
      vcount_in  = p.v;  vsync_in = p.vs; vblnk_in = p.vb;
      hit_valid  = hv;   hit_idx  = hi;
      load_valid = lv;   load_mask = lm;
      exp_rgb = model_rgb(m_prev);
      shown   = m_prev;
      model_update(p, hv, hi, lv, lm);
      m_prev = p;
      @(posedge pclk);
      #1;
      if (!m_skip_rgb) check("rgb", 32'(rgb_out), 32'(exp_rgb));
      m_skip_rgb = 1'b0;
      check("timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
            32'(shown));
      check("blocks", 32'(blocks_out), 32'(m_alive));
      check("flash_active", 32'(flash_active), 32'(m_cnt != 0));
      check("all_cleared", 32'(all_cleared), 32'(m_alive == 16'h0 && m_cnt == 0));
   endtask

   function automatic pix_t mk(input int h, input int v, input logic hb, input logic vb);
      pix_t p;
      p.h = 11'(h); p.hs = 1'b0; p.hb = hb;
      p.v = 11'(v); p.vs = 1'b0; p.vb = vb;
      return p;
   endfunction

   task automatic show(input int h, input int v, input int n);
      repeat (n) step(mk(h, v, 1'b0, 1'b0), 1'b0, 4'd0, 1'b0, 16'h0);
   endtask

   task automatic frame(input int h, input int v);
      show(h, v, 3);
      repeat (2) step(mk(h, v, 1'b0, 1'b1), 1'b0, 4'd0, 1'b0, 16'h0);
   endtask

   task automatic hit(input int h, input int v, input logic [3:0] idx);
      step(mk(h, v, 1'b0, 1'b0), 1'b1, idx, 1'b0, 16'h0);
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{25, 45, 1'b0, 1'b0, 12'h22f};
      vecs[1]  = '{125, 45, 1'b0, 1'b0, 12'h888};
      vecs[2]  = '{25, 45, 1'b1, 1'b0, 12'h000};
      vecs[3]  = '{20, 40, 1'b0, 1'b0, 12'h22f};
      vecs[4]  = '{19, 40, 1'b0, 1'b0, 12'h888};
      vecs[5]  = '{119, 89, 1'b0, 1'b0, 12'h22f};
      vecs[6]  = '{120, 45, 1'b0, 1'b0, 12'h888};
      vecs[7]  = '{25, 90, 1'b0, 1'b0, 12'h888};
      vecs[8]  = '{25, 45, 1'b0, 1'b1, 12'h000};
      vecs[9]  = '{245, 125, 1'b0, 1'b0, 12'h22f};
      vecs[10] = '{779, 329, 1'b0, 1'b0, 12'h22f};
      vecs[11] = '{780, 329, 1'b0, 1'b0, 12'h888};
      vecs[12] = '{900, 45, 1'b0, 1'b0, 12'h888};
      vecs[13] = '{500, 300, 1'b0, 1'b0, 12'h22f};

      reset = 1'b1;
      hcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
      vcount_in = '0; vsync_in = 1'b0; vblnk_in = 1'b0;
      hit_valid = 1'b0; hit_idx = '0; load_valid = 1'b0; load_mask = '0;
      model_reset();
      repeat (3) @(posedge pclk);
      #1;
      check("reset_rgb", 32'(rgb_out), 32'h0);
      check("reset_timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'h0);
      check("reset_blocks", 32'(blocks_out), 32'hffff);
      check("reset_flash", 32'(flash_active), 32'h0);
      check("reset_cleared", 32'(all_cleared), 32'h0);
      reset = 1'b0;

      // Pixel table with every brick alive.
      for (int i = 0; i < 14; i++) begin
         repeat (3) step(mk(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb), 1'b0, 4'd0, 1'b0, 16'h0);
         check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
      end

      // Hit brick 5: flashes for 8 frame ticks, then shows background.
      hit(245, 125, 4'd5);
      check("hit5_blocks", 32'(blocks_out[5]), 32'h0);
      for (int i = 0; i <= FLASH; i++) begin
         show(245, 125, 3);
         check($sformatf("flash5_f%0d_rgb", i), 32'(rgb_out), (i < FLASH) ? 32'hfff : 32'h888);
         check($sformatf("flash5_f%0d_act", i), 32'(flash_active), (i < FLASH) ? 32'h1 : 32'h0);
         if (i < FLASH) repeat (2) step(mk(245, 125, 1'b0, 1'b1), 1'b0, 4'd0, 1'b0, 16'h0);
      end

      // Hitting the already-dead brick does nothing.
      hit(245, 125, 4'd5);
      check("dead_hit_flash", 32'(flash_active), 32'h0);
      check("dead_hit_blocks", 32'(blocks_out), 32'hffdf);

      // A second hit mid-flash moves the flash and restarts its count.
      step(mk(25, 45, 1'b0, 1'b0), 1'b0, 4'd0, 1'b1, 16'hffff);
      hit(245, 125, 4'd5);
      frame(245, 125);
      frame(245, 125);
      hit(685, 45, 4'd3);
      show(685, 45, 3);
      check("flash3_rgb", 32'(rgb_out), 32'hfff);
      show(245, 125, 3);
      check("old5_rgb", 32'(rgb_out), 32'h888);
      repeat (FLASH - 1) frame(685, 45);
      show(685, 45, 3);
      check("flash3_before_last", 32'(flash_active), 32'h1);
      repeat (2) step(mk(685, 45, 1'b0, 1'b1), 1'b0, 4'd0, 1'b0, 16'h0);
      show(685, 45, 3);
      check("flash3_done_act", 32'(flash_active), 32'h0);
      check("flash3_done_rgb", 32'(rgb_out), 32'h888);

      // Load and hit in the same cycle: load wins, no flash.
      step(mk(25, 45, 1'b0, 1'b0), 1'b1, 4'd0, 1'b1, 16'h0001);
      check("load_hit_blocks", 32'(blocks_out), 32'h0001);
      check("load_hit_flash", 32'(flash_active), 32'h0);
      hit(25, 45, 4'd0);
      check("last_hit_cleared", 32'(all_cleared), 32'h0);
      repeat (FLASH) frame(25, 45);
      show(25, 45, 2);
      check("all_cleared", 32'(all_cleared), 32'h1);

      // Randomized traffic against the model.
      step(mk(25, 45, 1'b0, 1'b0), 1'b0, 4'd0, 1'b1, 16'hffff);
      for (int i = 0; i < 3000; i++) begin
         pix_t p;
         p.h  = 11'($urandom_range(0, 950));
         p.v  = 11'($urandom_range(0, 420));
         p.hs = 1'($urandom_range(0, 1));
         p.vs = 1'($urandom_range(0, 1));
         p.hb = ($urandom_range(0, 5) == 0);
         p.vb = ($urandom_range(0, 7) == 0);
         step(p, ($urandom_range(0, 6) == 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 150) == 0), 16'($urandom));
      end

      // Reset asserted mid-line during a flash clears everything immediately.
      step(mk(25, 45, 1'b0, 1'b0), 1'b0, 4'd0, 1'b1, 16'hffff);
      hit(25, 205, 4'd8);
      show(25, 205, 3);
      check("pre_reset_flash", 32'(flash_active), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_rgb", 32'(rgb_out), 32'h0);
      check("midreset_timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'h0);
      check("midreset_blocks", 32'(blocks_out), 32'hffff);
      check("midreset_flash", 32'(flash_active), 32'h0);
      @(posedge pclk);
      #1;
      reset = 1'b0;
      model_reset();
      show(25, 205, 3);
      check("post_reset_rgb", 32'(rgb_out), 32'h22f);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
